larpix_mosi_tx: RTL and testbench

//  Host/FPGA-side UART transmitter that drives one LArPix MOSI lane.
//  - Buffers 64-bit configuration/command packets in a small FIFO.
//  - Optionally fills the packet's odd-parity bit.
//  - Serializes each packet as a UART frame (start, 64 data bits LSB-first, stop, idle gap).
//  - The chip's RX UART samples this frame.
//  - One instance per lane; used in larpix_v3 testbenches and the FPGA controller.

---
 rtl/larpix_mosi_tx_if.sv | 20 ++
 rtl/larpix_mosi_tx.sv | 111 +++++++++++
 tb/tb_larpix_mosi_tx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/larpix_mosi_tx_if.sv
// larpix_mosi_tx_if: packet write handshake and serial line status of one LArPix MOSI lane
//   master : tx_data, tx_valid, fill_parity (driven by the packet source)
//   slave  : tx_ready, mosi, busy, packet_done, fifo_count (driven by the transmitter)
interface larpix_mosi_tx_if #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 4
) ();
  logic [WIDTH-1:0]              tx_data;
  logic                          tx_valid;
  logic                          fill_parity;
  logic                          tx_ready;
  logic                          mosi;
  logic                          busy;
  logic                          packet_done;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  modport master (output tx_data, tx_valid, fill_parity,
                  input  tx_ready, mosi, busy, packet_done, fifo_count);
  modport slave  (input  tx_data, tx_valid, fill_parity,
                  output tx_ready, mosi, busy, packet_done, fifo_count);
endinterface

// File: rtl/larpix_mosi_tx.sv
// larpix_mosi_tx: buffered UART transmitter for one LArPix MOSI lane
//   clk   : master clock
//   reset : asynchronous active-high reset; truncates any frame in flight
//   bus   : slave side of larpix_mosi_tx_if (packet push handshake, mosi line, status)
// Frame: start(0), WIDTH data bits LSB-first, stop(1), GAP_BITS idle bits, CLK_DIV clocks per bit.
module larpix_mosi_tx #(
  parameter int WIDTH      = 64,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 1
) (
  input logic            clk,
  input logic            reset,
  larpix_mosi_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam int NB = WIDTH > GAP_BITS ? WIDTH : GAP_BITS;
  localparam int BW = $clog2(NB + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             mosi_q, done_q;
  logic             push, pop, bit_end;
  logic [WIDTH-1:0] wr_word;

  assign bus.tx_ready    = cnt_q != (AW+1)'(FIFO_DEPTH);
  assign bus.busy        = state_q != IDLE || cnt_q != '0;
  assign bus.mosi        = mosi_q;
  assign bus.packet_done = done_q;
  assign bus.fifo_count  = cnt_q;

  assign push    = bus.tx_valid && bus.tx_ready;
  assign bit_end = div_q == DW'(CLK_DIV - 1);
  assign wr_word = bus.fill_parity ? {~^bus.tx_data[WIDTH-2:0], bus.tx_data[WIDTH-2:0]} : bus.tx_data;
  assign cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_d = state_q;
    div_d   = bit_end ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  div_d = '0;
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == BW'(WIDTH - 1) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        state_d = GAP_BITS > 0 ? GAP : IDLE;
        bit_d   = '0;
      end
      GAP: if (bit_end) begin
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == BW'(GAP_BITS - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    // Any cycle that would land in IDLE starts the next queued frame instead,
    // so queued packets go out with no extra idle clock between frames.
    if (state_d == IDLE && cnt_q != '0) begin
      pop     = 1'b1;
      state_d = START;
      div_d   = '0;
      shift_d = mem_q[rd_q];
    end
  end

  always_ff @(posedge clk) if (push) mem_q[wr_q] <= wr_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mosi_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      wr_q    <= push ? wr_q + 1'b1 : wr_q;
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      // Line and done pulse are registered from the current state, one clock behind the FSM.
      mosi_q  <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
      done_q  <= state_q == STOP && bit_end;
    end
  end
endmodule

// File: tb/tb_larpix_mosi_tx.sv
// tb_larpix_mosi_tx: randomized bench with a schedule-based reference model of the MOSI lane
module tb_larpix_mosi_tx;
  localparam int W    = 64;
  localparam int C    = 4;
  localparam int D    = 4;
  localparam int G    = 1;
  localparam int L    = (W + 2 + G) * C;
  localparam int DONE = (W + 2) * C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int              acc_q[$];
  int              pop_q[$];
  logic [W-1:0]    w_q[$];

  larpix_mosi_tx_if #(.WIDTH(W), .FIFO_DEPTH(D)) bus ();
  larpix_mosi_tx #(.WIDTH(W), .CLK_DIV(C), .FIFO_DEPTH(D), .GAP_BITS(G)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Expected outputs after edge n, from the absolute frame schedule: a packet accepted at
  // edge a is popped at max(a+1, previous pop + frame length); its line frame starts one
  // edge after the pop.
  function automatic void model_at(input int n, output logic m, output logic dn,
                                   output logic b, output int cnt);
    int p;
    logic fl;
    fl = 1'b0; cnt = 0; m = 1'b1; dn = 1'b0;
    foreach (acc_q[i]) if (acc_q[i] <= n) cnt++;
    foreach (pop_q[i]) begin
      if (pop_q[i] <= n) cnt--;
      p = n - pop_q[i] - 1;
      if (p >= 0 && p < C) m = 1'b0;
      else if (p >= C && p < C * (W + 1)) m = w_q[i][p / C - 1];
      if (n == pop_q[i] + DONE) dn = 1'b1;
      if (pop_q[i] <= n && n < pop_q[i] + L) fl = 1'b1;
    end
    b = fl || cnt > 0;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic m, dn, b;
    int cnt, s;
    logic [W-1:0] wd;
    if (reset) begin
      acc_q.delete(); pop_q.delete(); w_q.delete();
    end else begin
      cyc++;
      model_at(cyc - 1, m, dn, b, cnt);
      if (bus.tx_valid && cnt < D) begin
        wd = bus.tx_data;
        if (bus.fill_parity) wd[W-1] = ($countones(bus.tx_data[W-2:0]) % 2) == 0;
        s = cyc + 1;
        if (pop_q.size() > 0 && pop_q[$] + L > s) s = pop_q[$] + L;
        acc_q.push_back(cyc); pop_q.push_back(s); w_q.push_back(wd);
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic m, dn, b;
    int cnt;
    model_at(cyc, m, dn, b, cnt);
    chk("mosi", bus.mosi, m);
    chk("packet_done", bus.packet_done, dn);
    chk("busy", bus.busy, b);
    chk("fifo_count", bus.fifo_count, cnt);
    chk("tx_ready", bus.tx_ready, cnt < D);
  end

  task automatic push(input logic [63:0] d, input logic fp, input bit scramble,
                      output logic [63:0] took, output int acc);
    int t = 0;
    bus.tx_data = d; bus.fill_parity = fp; bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
      if (scramble) bus.tx_data = {$urandom, $urandom};
    end
    chk("push_wait_bound", t < 3000, 1);
    took = bus.tx_data;
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_fall(output int f);
    int t = 0;
    while (bus.mosi !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    chk("fall_wait_bound", t < 3000, 1);
    f = cyc;
  endtask

  task automatic capture(output logic [63:0] w, output int f);
    w = '0;
    wait_fall(f);
    for (int j = 1; j <= 263; j++) begin
      @(negedge clk);
      if (j == 2) chk("start_bit", bus.mosi, 0);
      if (j % 4 == 2 && j >= 6 && j <= 258) w[j / 4 - 1] = bus.mosi;
      if (j == 262) chk("stop_bit", bus.mosi, 1);
      if (j == 263) chk("packet_done_at_264", bus.packet_done, 1);
    end
  endtask

  initial begin
    logic [63:0] w, took, a, b;
    logic [63:0] dv[6];
    logic m, dn, bz;
    int f, acc, pf, cnt, t;
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.fill_parity = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mosi", bus.mosi, 1);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_done", bus.packet_done, 0);

    push(64'hA5, 1'b0, 1'b0, took, acc);
    bus.tx_valid = 1'b0;
    capture(w, f);
    chk("t1_latency", f - acc, 2);
    chk("t1_word", w, 64'h0000_0000_0000_00A5);
    chk("t1_low_byte", w[7:0], 8'b1010_0101);
    model_at(f, m, dn, bz, cnt);
    chk("pin_model_start", m, 0);
    model_at(f + 5, m, dn, bz, cnt);
    chk("pin_model_bit0", m, 1);
    model_at(f + 9, m, dn, bz, cnt);
    chk("pin_model_bit1", m, 0);
    model_at(f + 263, m, dn, bz, cnt);
    chk("pin_model_done", dn, 1);
    repeat (8) @(negedge clk);

    push(64'h0, 1'b1, 1'b0, took, acc);
    bus.tx_valid = 1'b0;
    capture(w, f);
    chk("t2_parity_zero", w, 64'h8000_0000_0000_0000);
    push(64'h1, 1'b1, 1'b0, took, acc);
    bus.tx_valid = 1'b0;
    capture(w, f);
    chk("t2_parity_one", w, 64'h1);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 5; i++) dv[i] = {$urandom, $urandom};
    fork
      begin
        for (int i = 0; i < 5; i++) push(dv[i], 1'b0, 1'b0, took, acc);
        bus.tx_valid = 1'b0;
        chk("t3_count_peak", bus.fifo_count, 4);
        chk("t3_ready_full", bus.tx_ready, 0);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          capture(w, f);
          chk("t3_order", w, dv[i]);
          if (i > 0) chk("t3_period", f - pf, 268);
          pf = f;
        end
      end
    join
    repeat (8) @(negedge clk);

    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    push(a, 1'b0, 1'b0, took, acc);
    push(b, 1'b0, 1'b0, took, acc);
    bus.tx_valid = 1'b0;
    wait_fall(f);
    repeat (C + 20 * C + 2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t4_mosi_async", bus.mosi, 1);
    chk("t4_count_async", bus.fifo_count, 0);
    chk("t4_busy_async", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    a = {$urandom, $urandom};
    push(a, 1'b0, 1'b0, took, acc);
    bus.tx_valid = 1'b0;
    capture(w, f);
    chk("t4_after_reset", w, a);
    repeat (8) @(negedge clk);

    fork
      begin
        for (int i = 0; i < 6; i++) push({$urandom, $urandom}, 1'b0, 1'b1, dv[i], acc);
        bus.tx_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          capture(w, f);
          chk("t5_held_word", w, dv[i]);
        end
      end
    join

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.tx_valid = $urandom_range(0, 2) == 0;
      bus.tx_data = {$urandom, $urandom};
      bus.fill_parity = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    t = 0;
    while (bus.busy !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    chk("drain_bound", t < 3000, 1);
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
